srm_controller: RTL and testbench
=================================

// Module: srm_controller
// PURPOSE
// Control FSM and instruction decoder that drives every control input of the SRM datapath and memory interface.
// Sequences fetch (IF1/IF2/UPDATE_PC), decode and a multi-cycle execute per instruction.
// Supports MOV imm, MOV reg, ADD, CMP, AND, MVN, LDR, STR and HALT.
// Consumes the instruction-register word. Produces register selects, mux selects, load enables, immediates and memory commands.
// PARAMETERS
// WORD_W   16  datapath word width; also the width of sximm5/sximm8
// RSEL_W   3   register-number width
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-high; forces state RST
// instr      in   WORD_W  IR output: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm
// readnum    out  RSEL_W  regfile read select
// writenum   out  RSEL_W  regfile write select
// write      out  1       regfile write enable
// vsel       out  2       write-back mux select: 00 mdata, 01 sximm8, 10 PC, 11 C
// loada      out  1       A register load enable
// loadb      out  1       B register load enable
// loadc      out  1       C register load enable
// loads      out  1       status register load enable
// asel       out  1       1 = A register, 0 = zero
// bsel       out  1       1 = shifter output, 0 = sximm5
// shift      out  2       shifter op
// ALUop      out  2       00 add, 01 sub, 10 and, 11 not-B
// sximm5     out  WORD_W  sign-extended instr[4:0]
// sximm8     out  WORD_W  sign-extended instr[7:0]
// load_pc    out  1       PC load enable
// reset_pc   out  1       PC next-value = 0
// load_ir    out  1       IR load enable
// load_addr  out  1       data-address register load enable
// addr_sel   out  1       1 = memory address from PC, 0 = from data-address register
// mem_cmd    out  2       00 NONE, 01 READ, 10 WRITE
// halted     out  1       high in HALT state
// BEHAVIOUR
// - Moore FSM; every control output is a combinational function of the state register (field-driven outputs also use instr).
// - Default for every enable: 0; mem_cmd = NONE; shift = 00; ALUop = 00.
// - reset asserted (any time, including mid-instruction): state <= RST immediately.
//   - In RST: reset_pc = 1 and load_pc = 1; all other enables are 0.
//   - Any in-flight write or STR is abandoned and does not complete.
// - Fetch: RST -> IF1 -> IF2 -> UPDATE_PC -> DECODE.
//   - IF1: addr_sel = 1, mem_cmd = READ.
//   - IF2: as IF1, plus load_ir = 1.
//   - UPDATE_PC: load_pc = 1.
// - DECODE (no outputs) dispatches on {opcode, op}:
//   - 110_10 MOV imm: WR_IMM: vsel = 01, writenum = Rn, write = 1. -> IF1 (5 cycles total).
//   - 110_00 MOV reg: GET_B (readnum = Rm, loadb) -> EXEC (asel = 0, bsel = 1, ALUop = 00, shift = sh, loadc) -> WR_RD (vsel = 11, writenum = Rd, write).
//   - 101_xx ALU: GET_A (readnum = Rn, loada) -> GET_B -> EXEC (asel = 1, bsel = 1, ALUop = op, shift = sh).
//     - ADD/AND: EXEC asserts loadc, then -> WR_RD.
//     - CMP: EXEC asserts loads only (loadc = 0), then -> IF1.
//     - MVN: skips GET_A and uses asel = 0.
//   - 011_00 LDR: GET_A -> ADDR (asel = 1, bsel = 0, ALUop = 00, loadc) -> LD_ADDR (load_addr) -> MEM_RD (addr_sel = 0, mem_cmd = READ) -> WR_MEM (addr_sel = 0, mem_cmd = READ, vsel = 00, writenum = Rd, write).
//   - 100_00 STR: GET_A -> ADDR -> LD_ADDR -> GET_RD (readnum = Rd, loadb) -> PASS (asel = 0, bsel = 1, shift = 00, loadc) -> MEM_WR (addr_sel = 0, mem_cmd = WRITE).
//   - 111_xx HALT, and any other encoding: -> HALT. HALT holds with halted = 1 until reset; all enables are 0.
// - Every execute path returns to IF1; PC is never reloaded outside RST/UPDATE_PC.
// - instr is sampled only from DECODE onward. IR changes only in IF2, so it is stable for a whole execute.
// - sximm5/sximm8 are pure sign extension: sximm8 = {{8{instr[7]}}, instr[7:0]}.
// STRUCTURE
// - srm_pkg: state enum, opcode/op constants, MEM_NONE/MEM_READ/MEM_WRITE, VSEL_* constants.
// - One sub-module, srm_instr_decoder (combinational): field extraction, sign extension, and Rn/Rd/Rm select mux driven by a one-hot nsel from the FSM.
// - FSM (state register + next-state + output decode) lives in this file.
// TESTING
// - reset high mid-EXEC of ADD -> same cycle: write = 0, loadc = 0, reset_pc = 1, load_pc = 1. After release: IF1 follows, mem_cmd = 01.
// - instr = 16'hD107 (MOV R1,#7) -> exactly 5 cycles IF1..WR_IMM. In WR_IMM: writenum = 1, vsel = 01, sximm8 = 16'h0007. sximm8 = 16'hFFF9 for imm8 = 8'hF9.
// - instr = 16'hA0A2 (ADD R5,R0,R2) -> GET_A readnum = 0, GET_B readnum = 2, EXEC ALUop = 00 with loadc = 1, WR_RD writenum = 5 with vsel = 11. Next: IF1.
// - instr = 16'hA9E3 (CMP R1,R3) -> EXEC: loads = 1, loadc = 0, ALUop = 01. No cycle with write = 1 before the next IF1.
// - instr = 16'h8264 (STR R3,[R2,#4]) -> ADDR: bsel = 0, sximm5 = 4. GET_RD: readnum = 3. MEM_WR: mem_cmd = 10, addr_sel = 0. Then: LDR of the same address writes Rd with vsel = 00.
// - instr = 16'hE000 (HALT) or 16'h0000 (illegal) -> halted = 1; all enables stay 0 for 20 cycles; reset recovers to RST.

Source files
------------

// File: rtl/srm_pkg.sv
// Shared types and encodings for the SRM controller: FSM states, opcode/op fields,
// memory commands, write-back mux selects and register-select one-hot positions.
package srm_pkg;

    typedef enum logic [4:0] {
        StRst,
        StIf1,
        StIf2,
        StUpdatePc,
        StDecode,
        StWrImm,
        StGetA,
        StGetB,
        StExec,
        StWrRd,
        StAddr,
        StLdAddr,
        StMemRd,
        StWrMem,
        StGetRd,
        StPass,
        StMemWr,
        StHalt
    } state_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] SH_NONE = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b11;

    // Bit positions inside the one-hot register-field select.
    localparam int unsigned NSEL_RN = 0;
    localparam int unsigned NSEL_RD = 1;
    localparam int unsigned NSEL_RM = 2;

endpackage

// File: rtl/srm_instr_decoder.sv
// Combinational instruction-word decoder: field extraction, immediate sign extension
// and the Rn/Rd/Rm register-number mux steered by a one-hot select from the FSM.
module srm_instr_decoder
    import srm_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned RSEL_W = 3
) (
    input  logic [WORD_W-1:0] instr_i,
    input  logic [2:0]        nsel_i,
    output logic [2:0]        opcode_o,
    output logic [1:0]        op_o,
    output logic [1:0]        sh_o,
    output logic [RSEL_W-1:0] rsel_o,
    output logic [WORD_W-1:0] sximm5_o,
    output logic [WORD_W-1:0] sximm8_o
);

    logic [RSEL_W-1:0] rn;
    logic [RSEL_W-1:0] rd;
    logic [RSEL_W-1:0] rm;

    assign opcode_o = instr_i[15:13];
    assign op_o     = instr_i[12:11];
    assign sh_o     = instr_i[4:3];

    assign rn = RSEL_W'(instr_i[10:8]);
    assign rd = RSEL_W'(instr_i[7:5]);
    assign rm = RSEL_W'(instr_i[2:0]);

    // AND-OR mux: an all-zero select yields register 0.
    assign rsel_o = ({RSEL_W{nsel_i[NSEL_RN]}} & rn)
                  | ({RSEL_W{nsel_i[NSEL_RD]}} & rd)
                  | ({RSEL_W{nsel_i[NSEL_RM]}} & rm);

    assign sximm5_o = {{(WORD_W - 5){instr_i[4]}}, instr_i[4:0]};
    assign sximm8_o = {{(WORD_W - 8){instr_i[7]}}, instr_i[7:0]};

endmodule

// File: rtl/srm_controller.sv
// SRM control FSM: fetch, decode and multi-cycle execute, driving every datapath and
// memory-interface control as a Moore function of the state (plus instruction fields).
module srm_controller
    import srm_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned RSEL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] instr,
    output logic [RSEL_W-1:0] readnum,
    output logic [RSEL_W-1:0] writenum,
    output logic              write,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [WORD_W-1:0] sximm5,
    output logic [WORD_W-1:0] sximm8,
    output logic              load_pc,
    output logic              reset_pc,
    output logic              load_ir,
    output logic              load_addr,
    output logic              addr_sel,
    output logic [1:0]        mem_cmd,
    output logic              halted
);

    state_e            state_q;
    state_e            state_d;
    logic [2:0]        nsel;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [1:0]        sh;
    logic [RSEL_W-1:0] rsel;
    logic              is_alu;
    logic              is_cmp;

    srm_instr_decoder #(
        .WORD_W (WORD_W),
        .RSEL_W (RSEL_W)
    ) u_decoder (
        .instr_i  (instr),
        .nsel_i   (nsel),
        .opcode_o (opcode),
        .op_o     (op),
        .sh_o     (sh),
        .rsel_o   (rsel),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8)
    );

    assign readnum  = rsel;
    assign writenum = rsel;
    assign is_alu   = (opcode == OPC_ALU);
    assign is_cmp   = is_alu && (op == OP_CMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nsel      = 3'b000;
        write     = 1'b0;
        vsel      = VSEL_MDATA;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = SH_NONE;
        ALUop     = ALU_ADD;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;

        case (state_q)
            StRst: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = StIf1;
            end
            StIf1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                state_d  = StIf2;
            end
            StIf2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
                state_d  = StUpdatePc;
            end
            StUpdatePc: begin
                load_pc = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                // Unrecognised encodings fall into HALT rather than executing garbage.
                if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
                    state_d = StWrImm;
                end else if (opcode == OPC_MOV && op == OP_MOV_REG) begin
                    state_d = StGetB;
                end else if (is_alu) begin
                    state_d = (op == OP_MVN) ? StGetB : StGetA;
                end else if ((opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM) begin
                    state_d = StGetA;
                end else begin
                    state_d = StHalt;
                end
            end
            StWrImm: begin
                nsel[NSEL_RN] = 1'b1;
                vsel          = VSEL_IMM8;
                write         = 1'b1;
                state_d       = StIf1;
            end
            StGetA: begin
                nsel[NSEL_RN] = 1'b1;
                loada         = 1'b1;
                state_d       = is_alu ? StGetB : StAddr;
            end
            StGetB: begin
                nsel[NSEL_RM] = 1'b1;
                loadb         = 1'b1;
                state_d       = StExec;
            end
            StExec: begin
                // MOV reg and MVN pass B through with A forced to zero.
                asel  = is_alu && (op != OP_MVN);
                bsel  = 1'b1;
                ALUop = is_alu ? op : ALU_ADD;
                shift = sh;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = StIf1;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWrRd;
                end
            end
            StWrRd: begin
                nsel[NSEL_RD] = 1'b1;
                vsel          = VSEL_C;
                write         = 1'b1;
                state_d       = StIf1;
            end
            StAddr: begin
                asel    = 1'b1;
                bsel    = 1'b0;
                ALUop   = ALU_ADD;
                loadc   = 1'b1;
                state_d = StLdAddr;
            end
            StLdAddr: begin
                load_addr = 1'b1;
                state_d   = (opcode == OPC_STR) ? StGetRd : StMemRd;
            end
            StMemRd: begin
                addr_sel = 1'b0;
                mem_cmd  = MEM_READ;
                state_d  = StWrMem;
            end
            StWrMem: begin
                nsel[NSEL_RD] = 1'b1;
                addr_sel      = 1'b0;
                mem_cmd       = MEM_READ;
                vsel          = VSEL_MDATA;
                write         = 1'b1;
                state_d       = StIf1;
            end
            StGetRd: begin
                nsel[NSEL_RD] = 1'b1;
                loadb         = 1'b1;
                state_d       = StPass;
            end
            StPass: begin
                asel    = 1'b0;
                bsel    = 1'b1;
                shift   = SH_NONE;
                loadc   = 1'b1;
                state_d = StMemWr;
            end
            StMemWr: begin
                addr_sel = 1'b0;
                mem_cmd  = MEM_WRITE;
                state_d  = StIf1;
            end
            StHalt: begin
                halted  = 1'b1;
                state_d = StHalt;
            end
            default: begin
                state_d = StRst;
            end
        endcase
    end

endmodule

// File: tb/tb_srm_controller.sv
// Scoreboard bench for srm_controller: stimulus queues the expected per-cycle control
// word for each instruction; a monitor pops and compares one entry per falling edge.
module tb_srm_controller;

    typedef struct packed {
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        load_pc;
        logic        reset_pc;
        logic        load_ir;
        logic        load_addr;
        logic        halted;
        logic [1:0]  mem_cmd;
        logic        addr_sel;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
        obs_t  m;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop, mem_cmd;
    logic [15:0] sximm5, sximm8;
    logic        load_pc, reset_pc, load_ir, load_addr, addr_sel, halted;

    obs_t obs;
    obs_t ev;
    obs_t em;
    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    srm_controller #(
        .WORD_W (16),
        .RSEL_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .readnum   (readnum),
        .writenum  (writenum),
        .write     (write),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .shift     (shift),
        .ALUop     (ALUop),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_ir   (load_ir),
        .load_addr (load_addr),
        .addr_sel  (addr_sel),
        .mem_cmd   (mem_cmd),
        .halted    (halted)
    );

    assign obs = {write, loada, loadb, loadc, loads, load_pc, reset_pc, load_ir, load_addr,
                  halted, mem_cmd, addr_sel, asel, bsel, vsel, shift, ALUop, readnum,
                  writenum, sximm5, sximm8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : monitor
        exp_t cur;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                cur = q.pop_front();
                n_vec++;
                if (((obs ^ cur.v) & cur.m) !== '0) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (mask %h)", cur.tag,
                             obs & cur.m, cur.v & cur.m, cur.m);
                end
            end
        end
    end

    // Every enable and mem_cmd is always checked (expected 0 / NONE unless set).
    task automatic base();
        ev = '0;
        em = '0;
        {em.write, em.loada, em.loadb, em.loadc, em.loads} = '1;
        {em.load_pc, em.reset_pc, em.load_ir, em.load_addr, em.halted} = '1;
        em.mem_cmd = '1;
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = ev;
        e.m   = em;
        q.push_back(e);
    endtask

    task automatic sel_rd(input logic [2:0] r);
        ev.readnum = r;
        em.readnum = '1;
    endtask

    task automatic sel_wr(input logic [2:0] r);
        ev.writenum = r;
        em.writenum = '1;
    endtask

    task automatic mux(input logic as, input logic bs, input logic [1:0] alu,
                       input logic [1:0] sh);
        ev.asel  = as;
        ev.bsel  = bs;
        ev.aluop = alu;
        ev.shift = sh;
        {em.asel, em.bsel} = '1;
        em.aluop = '1;
        em.shift = '1;
    endtask

    task automatic p_rst(input string tag);
        base(); ev.reset_pc = 1'b1; ev.load_pc = 1'b1; push(tag);
    endtask

    task automatic p_if(input string tag, input logic ir);
        base(); ev.addr_sel = 1'b1; em.addr_sel = 1'b1; ev.mem_cmd = 2'b01;
        ev.load_ir = ir; push(tag);
    endtask

    task automatic p_fetch();
        p_if("IF1", 1'b0);
        p_if("IF2", 1'b1);
        base(); ev.load_pc = 1'b1; push("UPDATE_PC");
        base(); push("DECODE");
    endtask

    task automatic p_geta(input logic [2:0] rn);
        base(); ev.loada = 1'b1; sel_rd(rn); push("GET_A");
    endtask

    task automatic p_getb(input logic [2:0] rm);
        base(); ev.loadb = 1'b1; sel_rd(rm); push("GET_B");
    endtask

    task automatic p_exec(input logic as, input logic [1:0] alu, input logic [1:0] sh,
                          input logic cmp);
        base(); mux(as, 1'b1, alu, sh);
        if (cmp) ev.loads = 1'b1;
        else     ev.loadc = 1'b1;
        push("EXEC");
    endtask

    task automatic p_wrrd(input logic [2:0] rd);
        base(); ev.write = 1'b1; ev.vsel = 2'b11; em.vsel = '1; sel_wr(rd); push("WR_RD");
    endtask

    task automatic p_wrimm(input logic [2:0] rn, input logic [15:0] s8, input logic [15:0] s5);
        base(); ev.write = 1'b1; ev.vsel = 2'b01; em.vsel = '1; sel_wr(rn);
        ev.sximm8 = s8; em.sximm8 = '1; ev.sximm5 = s5; em.sximm5 = '1;
        push("WR_IMM");
    endtask

    task automatic p_addr(input logic [15:0] s5);
        base(); mux(1'b1, 1'b0, 2'b00, 2'b00); em.shift = '0; ev.loadc = 1'b1;
        ev.sximm5 = s5; em.sximm5 = '1; push("ADDR");
    endtask

    task automatic p_mem(input string tag, input logic [1:0] cmd);
        base(); ev.mem_cmd = cmd; em.addr_sel = 1'b1; push(tag);
    endtask

    task automatic start(input logic [15:0] w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        instr = w;
        p_rst("RST");
    endtask

    task automatic go();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d entries left, required 0", q.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    initial begin : stimulus
        reset = 1'b1;
        instr = 16'h0000;

        // MOV R1,#7
        start(16'hD107); p_fetch(); p_wrimm(3'd1, 16'h0007, 16'h0007); p_if("IF1 after MOV", 1'b0);
        go(); drain();

        // MOV R1,#-7: both immediates sign-extend negative
        start(16'hD1F9); p_fetch(); p_wrimm(3'd1, 16'hFFF9, 16'hFFF9); p_if("IF1", 1'b0);
        go(); drain();

        // ADD R5,R0,R2
        start(16'hA0A2); p_fetch(); p_geta(3'd0); p_getb(3'd2);
        p_exec(1'b1, 2'b00, 2'b00, 1'b0); p_wrrd(3'd5); p_if("IF1 after ADD", 1'b0);
        go(); drain();

        // CMP R1,R3: status only, no write-back
        start(16'hA9E3); p_fetch(); p_geta(3'd1); p_getb(3'd3);
        p_exec(1'b1, 2'b01, 2'b00, 1'b1); p_if("IF1 after CMP", 1'b0);
        go(); drain();

        // MVN R2,R1 with shift 01: no GET_A, asel = 0
        start(16'hB849); p_fetch(); p_getb(3'd1);
        p_exec(1'b0, 2'b11, 2'b01, 1'b0); p_wrrd(3'd2); p_if("IF1 after MVN", 1'b0);
        go(); drain();

        // MOV R6,R5 with shift 10
        start(16'hC0D5); p_fetch(); p_getb(3'd5);
        p_exec(1'b0, 2'b00, 2'b10, 1'b0); p_wrrd(3'd6); p_if("IF1 after MOVR", 1'b0);
        go(); drain();

        // STR R3,[R2,#4]
        start(16'h8264); p_fetch(); p_geta(3'd2); p_addr(16'h0004);
        base(); ev.load_addr = 1'b1; push("LD_ADDR");
        base(); ev.loadb = 1'b1; sel_rd(3'd3); push("GET_RD");
        base(); mux(1'b0, 1'b1, 2'b00, 2'b00); ev.loadc = 1'b1; push("PASS");
        p_mem("MEM_WR", 2'b10); p_if("IF1 after STR", 1'b0);
        go(); drain();

        // LDR R3,[R2,#4]
        start(16'h6264); p_fetch(); p_geta(3'd2); p_addr(16'h0004);
        base(); ev.load_addr = 1'b1; push("LD_ADDR");
        p_mem("MEM_RD", 2'b01);
        base(); ev.mem_cmd = 2'b01; em.addr_sel = 1'b1; ev.write = 1'b1;
        em.vsel = '1; sel_wr(3'd3); push("WR_MEM");
        p_if("IF1 after LDR", 1'b0);
        go(); drain();

        // Reset during EXEC of ADD: RST outputs in that same cycle, then IF1
        start(16'hA0A2); p_fetch(); p_geta(3'd0); p_getb(3'd2);
        p_rst("RST mid EXEC"); p_if("IF1 after reset", 1'b0);
        go();
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        drain();

        // HALT, then an illegal encoding: both park in HALT
        start(16'hE000); p_fetch();
        for (int i = 0; i < 20; i++) begin base(); ev.halted = 1'b1; push("HALT E000"); end
        go(); drain();

        start(16'h0000); p_fetch();
        for (int i = 0; i < 20; i++) begin base(); ev.halted = 1'b1; push("HALT 0000"); end
        go(); drain();

        // Reset out of HALT restarts fetch
        start(16'hD107); p_fetch(); p_wrimm(3'd1, 16'h0007, 16'h0007); p_if("IF1 recovered", 1'b0);
        go(); drain();

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
